// File: rtl/seq_bam8_ctrl.sv
// Sequential 8x8 broken-array multiplier, one partial-product row per cycle.
// Ports: clk/rst_n, in_valid/in_ready + a,b,cfg_h,cfg_v, abort, out_valid/out_ready + result, busy.
module seq_bam8_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic [3:0]  cfg_h,
  input  logic [4:0]  cfg_v,
  input  logic        abort,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t      state;
  logic [7:0]  a_reg;
  logic [7:0]  b_reg;
  logic [4:0]  v_reg;
  logic [3:0]  row;
  logic [15:0] acc;

  logic [7:0]  mask;
  logic [15:0] term;
  logic [15:0] acc_nxt;
  logic [3:0]  row_first;

  // mask bit i keeps a[i] when its weight i+row reaches the vertical cut
  always_comb begin
    mask = '0;
    for (int i = 0; i < 8; i++) begin
      mask[i] = (5'(i) + {1'b0, row}) >= v_reg;
    end
    term = '0;
    if (b_reg[row[2:0]]) begin
      term = {8'd0, a_reg & mask} << row;
    end
    acc_nxt   = acc + term;
    row_first = cfg_h[3] ? 4'd8 : cfg_h;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      result    <= '0;
      acc       <= '0;
      row       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      v_reg     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_reg    <= a;
            b_reg    <= b;
            v_reg    <= cfg_v;
            acc      <= '0;
            row      <= row_first;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (row_first == 4'd8) begin
              state     <= DONE;
              result    <= '0;
              out_valid <= 1'b1;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (abort) begin
            state     <= IDLE;
            result    <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end else begin
            acc <= acc_nxt;
            row <= row + 4'd1;
            if (row == 4'd7) begin
              state     <= DONE;
              result    <= acc_nxt;
              out_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (abort) begin
            state     <= IDLE;
            result    <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end else if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
